// File: rtl/xmon_pkg.sv
// Shared types for the X-propagation monitor: event record and the X/Z test.
// Event record widths follow the package defaults for lane count and timestamp width.
package xmon_pkg;

    localparam int XMON_N_LANES = 4;
    localparam int XMON_CYC_W   = 16;
    localparam int XMON_LANE_W  = (XMON_N_LANES > 1) ? $clog2(XMON_N_LANES) : 1;

    typedef struct packed {
        logic [XMON_LANE_W-1:0] lane;
        logic [XMON_CYC_W-1:0]  cycle;
    } xmon_evt_t;

    function automatic logic xmon_is_x(input logic b);
        return (b !== 1'b0) && (b !== 1'b1);
    endfunction

endpackage

// File: rtl/xmon_evt_fifo.sv
// Small FIFO of violation events with async active-low reset.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module xmon_evt_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    entry_t         mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: the read side is masked by empty in the top.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/xprop_monitor.sv
// Per-lane X/Z detector with resolved lane forwarding, saturating counters and an event queue.
// XMON_HOLD_LAST_EN: when defined, an X lane holds its last known value instead of forcing 0.
module xprop_monitor
    import xmon_pkg::*;
#(
    parameter int N_LANES = XMON_N_LANES,
    parameter int CNT_W   = 8,
    parameter int CYC_W   = XMON_CYC_W,
    parameter int DEPTH   = 4,
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LANES-1:0] lane_in,
    output logic [N_LANES-1:0] lane_out,
    output logic [N_LANES-1:0] err_sticky,
    input  logic               cnt_clr,
    input  logic [LANE_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0]   cnt_val,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [LANE_W-1:0]  evt_lane,
    output logic [CYC_W-1:0]   evt_cycle,
    output logic               evt_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_LANES-1:0] x_det;
    logic               ready_k;
    logic               clr_k;
    logic [LANE_W-1:0]  sel_k;

    logic [CYC_W-1:0]   cyc;
    logic [CNT_W-1:0]   cnt   [N_LANES];
    logic [CYC_W-1:0]   stamp [N_LANES];
    logic [N_LANES-1:0] pending;
    logic [N_LANES-1:0] pend_base;

    logic               pick_valid;
    logic [LANE_W-1:0]  pick_lane;
    logic               push;
    logic               pop;
    logic               coalesce;
    xmon_evt_t          push_data;
    xmon_evt_t          head;
    logic               fifo_full;
    logic               fifo_empty;

    // Unknown control inputs are read as 0 so they can never trigger a pop or clear.
    always_comb begin
        ready_k = xmon_is_x(evt_ready) ? 1'b0 : evt_ready;
        clr_k   = xmon_is_x(cnt_clr) ? 1'b0 : cnt_clr;
        sel_k   = '0;
        for (int b = 0; b < LANE_W; b++) begin
            sel_k[b] = xmon_is_x(cnt_sel[b]) ? 1'b0 : cnt_sel[b];
        end
        x_det = '0;
        for (int i = 0; i < N_LANES; i++) begin
            x_det[i] = xmon_is_x(lane_in[i]);
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_lane  = '0;
        for (int i = N_LANES-1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_valid = 1'b1;
                pick_lane  = LANE_W'(i);
            end
        end
    end

    assign pop  = evt_valid && ready_k;
    assign push = pick_valid && (!fifo_full || pop);

    // A lane drained by this edge's push may re-pend on a fresh X without coalescing.
    always_comb begin
        pend_base = pending;
        if (push) pend_base[pick_lane] = 1'b0;
        coalesce  = |(x_det & pend_base);
        push_data = '{lane: pick_lane, cycle: stamp[pick_lane]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc          <= '0;
            pending      <= '0;
            evt_overflow <= 1'b0;
            for (int i = 0; i < N_LANES; i++) stamp[i] <= '0;
        end else begin
            cyc          <= cyc + CYC_W'(1);
            pending      <= pend_base | x_det;
            evt_overflow <= clr_k ? 1'b0 : (evt_overflow | coalesce);
            for (int i = 0; i < N_LANES; i++) begin
                if (x_det[i] && !pend_base[i]) stamp[i] <= cyc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= '0;
            for (int i = 0; i < N_LANES; i++) cnt[i] <= '0;
        end else begin
            err_sticky <= clr_k ? x_det : (err_sticky | x_det);
            for (int i = 0; i < N_LANES; i++) begin
                if (clr_k) begin
                    cnt[i] <= CNT_W'(x_det[i]);
                end else if (x_det[i] && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_out <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (!x_det[i]) begin
                    lane_out[i] <= lane_in[i];
                end else begin
`ifdef XMON_HOLD_LAST_EN
                    lane_out[i] <= lane_out[i];
`else
                    lane_out[i] <= 1'b0;
`endif
                end
            end
        end
    end

    xmon_evt_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (xmon_evt_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_lane  = fifo_empty ? '0 : head.lane;
    assign evt_cycle = fifo_empty ? '0 : head.cycle;

    always_comb begin
        cnt_val = '0;
        if (int'(sel_k) < N_LANES) cnt_val = cnt[sel_k];
    end

endmodule

// File: tb/tb_xprop_monitor.sv
// Self-checking bench for xprop_monitor: queue-based reference model plus directed scenarios.
module tb_xprop_monitor;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CMAX  = 255;
`ifdef XMON_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] lane_in;
    logic [N-1:0] lane_out;
    logic [N-1:0] err_sticky;
    logic         cnt_clr;
    logic [1:0]   cnt_sel;
    logic [7:0]   cnt_val;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_lane;
    logic [15:0]  evt_cycle;
    logic         evt_overflow;

    xprop_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lane_in      (lane_in),
        .lane_out     (lane_out),
        .err_sticky   (err_sticky),
        .cnt_clr      (cnt_clr),
        .cnt_sel      (cnt_sel),
        .cnt_val      (cnt_val),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_lane     (evt_lane),
        .evt_cycle    (evt_cycle),
        .evt_overflow (evt_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lane;
        int cyc;
    } mev_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    bit     x_ok;
    int     m_cnt [N];
    int     m_stamp [N];
    bit [N-1:0] m_sticky;
    bit [N-1:0] m_pend;
    bit [N-1:0] m_lout;
    bit     m_ovf;
    int     m_cyc;
    mev_t   m_q [$];
    int     cur_sel;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]   = 0;
            m_stamp[i] = 0;
        end
        m_sticky = '0;
        m_pend   = '0;
        m_lout   = '0;
        m_ovf    = 1'b0;
        m_cyc    = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic [N-1:0] li, input logic clr, input logic rdy);
        bit [N-1:0] xv;
        bit rk, ck, pop, can_push;
        int lowest;
        for (int i = 0; i < N; i++) xv[i] = (li[i] !== 1'b0) && (li[i] !== 1'b1);
        rk = (rdy === 1'b1);
        ck = (clr === 1'b1);
        pop = rk && (m_q.size() > 0);
        lowest = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) begin
                lowest = i;
                break;
            end
        end
        can_push = (lowest >= 0) && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (can_push) begin
            m_q.push_back('{lowest, m_stamp[lowest]});
            m_pend[lowest] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (xv[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i]  = 1'b1;
                    m_stamp[i] = m_cyc;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (ck) m_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ck) begin
                m_cnt[i]    = 0;
                m_sticky[i] = 1'b0;
            end
            if (xv[i]) begin
                m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                m_sticky[i] = 1'b1;
            end
            if (xv[i]) m_lout[i] = HOLD ? m_lout[i] : 1'b0;
            else       m_lout[i] = li[i];
        end
        m_cyc = (m_cyc + 1) % 65536;
    endtask

    task automatic compare_all();
        check("lane_out", lane_out, m_lout);
        check("err_sticky", err_sticky, m_sticky);
        check("cnt_val", cnt_val, m_cnt[cur_sel]);
        check("evt_valid", evt_valid, (m_q.size() > 0));
        check("evt_lane", evt_lane, (m_q.size() > 0) ? m_q[0].lane : 0);
        check("evt_cycle", evt_cycle, (m_q.size() > 0) ? m_q[0].cyc : 0);
        check("evt_overflow", evt_overflow, m_ovf);
    endtask

    // Called at a falling edge: drive, let one rising edge happen, then compare.
    task automatic cycle(input logic [N-1:0] li, input logic clr, input logic rdy, input logic [1:0] sel);
        lane_in   = li;
        cnt_clr   = clr;
        evt_ready = rdy;
        cnt_sel   = sel;
        cur_sel   = int'(sel);
        @(posedge clk);
        model_step(li, clr, rdy);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic probe;
        logic [N-1:0] li;
        logic rdy;
        int r;

        probe = 1'bx;
        x_ok  = (probe !== 1'b0) && (probe !== 1'b1);

        rst_n     = 1'b0;
        lane_in   = '0;
        cnt_clr   = 1'b0;
        evt_ready = 1'b0;
        cnt_sel   = '0;
        cur_sel   = 0;
        model_reset();
        #2;
        check("rst_lane_out", lane_out, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_cnt_val", cnt_val, 0);
        check("rst_overflow", evt_overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Lane 2 unknown at the edge whose stamp is 10.
        while (m_cyc != 10) cycle(4'b0000, 1'b0, 1'b1, 2'd2);
        cycle(4'b0x00, 1'b0, 1'b1, 2'd2);
        if (x_ok) begin
            check("t1_lane_out2", lane_out[2], 0);
            check("t1_cnt2", cnt_val, 1);
            check("t1_sticky2", err_sticky[2], 1);
        end
        cycle(4'b0000, 1'b0, 1'b1, 2'd2);
        if (x_ok) begin
            check("t1_valid", evt_valid, 1);
            check("t1_lane", evt_lane, 2);
            check("t1_cycle", evt_cycle, 10);
        end

        // Lanes 0 and 3 together at stamp 20 queue in ascending order.
        while (m_cyc != 20) cycle(4'b0000, 1'b0, 1'b1, 2'd0);
        cycle(4'bx00x, 1'b0, 1'b1, 2'd0);
        cycle(4'b0000, 1'b0, 1'b1, 2'd0);
        if (x_ok) begin
            check("t2_first_lane", evt_lane, 0);
            check("t2_first_cycle", evt_cycle, 20);
        end
        cycle(4'b0000, 1'b0, 1'b1, 2'd0);
        if (x_ok) begin
            check("t2_second_lane", evt_lane, 3);
            check("t2_second_cycle", evt_cycle, 20);
        end
        check("t2_overflow", evt_overflow, 0);
        repeat (4) cycle(4'b0000, 1'b0, 1'b1, 2'd0);

        // Clear coincident with an X: clear first, then count.
        cycle(4'b000x, 1'b1, 1'b1, 2'd0);
        if (x_ok) begin
            check("t5_cnt0", cnt_val, 1);
            check("t5_sticky0", err_sticky[0], 1);
        end
        check("t5_overflow", evt_overflow, 0);
        repeat (4) cycle(4'b0000, 1'b0, 1'b1, 2'd1);

        // Known value then X on lane 1.
        cycle(4'b0010, 1'b0, 1'b1, 2'd1);
        check("t6_known", lane_out[1], 1);
        cycle(4'b00x0, 1'b0, 1'b1, 2'd1);
        if (x_ok) check("t6_lane_out1", lane_out[1], HOLD ? 1 : 0);
        repeat (4) cycle(4'b0000, 1'b0, 1'b1, 2'd1);

        // Consumer stalled, lane 1 unknown for 300 edges.
        cycle(4'b0000, 1'b1, 1'b1, 2'd1);
        repeat (300) cycle(4'b00x0, 1'b0, 1'b0, 2'd1);
        if (x_ok) begin
            check("t3_cnt_sat", cnt_val, 255);
            check("t3_overflow", evt_overflow, 1);
            check("t3_valid", evt_valid, 1);
        end
        repeat (10) cycle(4'b0000, 1'b0, 1'b1, 2'd1);

        // Three entries queued, then an asynchronous reset between edges.
        cycle(4'b0xxx, 1'b0, 1'b0, 2'd0);
        repeat (3) cycle(4'b1010, 1'b0, 1'b0, 2'd0);
        if (x_ok) begin
            check("t4_pre_valid", evt_valid, 1);
            check("t4_pre_lane", evt_lane, 0);
        end
        check("t4_pre_lane_out", lane_out, 4'b1010);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("t4_valid", evt_valid, 0);
        check("t4_lane_out", lane_out, 0);
        check("t4_cnt", cnt_val, 0);
        check("t4_sticky", err_sticky, 0);
        check("t4_overflow", evt_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      li[i] = 1'bx;
                else if (r == 1) li[i] = 1'bz;
                else             li[i] = 1'($urandom_range(0, 1));
            end
            r = $urandom_range(0, 9);
            if (r == 0)      rdy = 1'bx;
            else if (r < 4)  rdy = 1'b0;
            else             rdy = 1'b1;
            cycle(li, ($urandom_range(0, 29) == 0), rdy, 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
